// File: rtl/cr_tlvp_axi_out_mstr.sv
// Drains the TLV parser's show-ahead outbound FIFO into an AXI4-Stream master through a small
// skid buffer, with optional parking at frame boundaries and wrapping frame/beat counters.
package cr_tlvp_axi_pkg;
  typedef struct packed {
    logic        tvalid;
    logic        tlast;
    logic [1:0]  tid;
    logic [7:0]  tuser;
    logic [7:0]  tstrb;
    logic [63:0] tdata;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;
endpackage

module cr_tlvp_axi_out_mstr
  import cr_tlvp_axi_pkg::*;
#(
  parameter int N_OB_ENTRIES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tlvp_ob_empty,
  input  logic                 tlvp_ob_aempty,
  input  axi4s_dp_bus_t        tlvp_ob,
  output logic                 tlvp_ob_rd,
  input  logic                 frame_hold,
  input  axi4s_dp_rdy_t        axi4s_ob_in,
  output axi4s_dp_bus_t        axi4s_ob_out,
  output logic                 ob_held,
  output logic [CNT_WIDTH-1:0] ob_frame_cnt,
  output logic [CNT_WIDTH-1:0] ob_beat_cnt
);

  localparam int CW = $clog2(N_OB_ENTRIES + 1);

  typedef enum logic [1:0] {IDLE, IN_FRM, HELD} state_t;

  state_t                 state_q, state_d;
  axi4s_dp_bus_t          ent_q [N_OB_ENTRIES];
  axi4s_dp_bus_t          ent_d [N_OB_ENTRIES];
  axi4s_dp_bus_t          push_beat;
  logic [CW-1:0]          cnt_q, cnt_d, wr_idx;
  logic                   ob_held_q, ob_held_d;
  logic [CNT_WIDTH-1:0]   frame_cnt_q, beat_cnt_q;
  logic                   push, pop, fsm_allows_rd;
  logic                   unused_inputs;

  // Almost-empty and the FIFO's own tvalid carry no information this block needs.
  assign unused_inputs = tlvp_ob_aempty ^ tlvp_ob.tvalid;

  assign pop           = ent_q[0].tvalid & axi4s_ob_in.tready;
  assign fsm_allows_rd = (state_q == IN_FRM) | ((state_q == IDLE) & ~frame_hold);
  assign tlvp_ob_rd    = ~rst & ~tlvp_ob_empty & ((cnt_q < CW'(N_OB_ENTRIES)) | pop) & fsm_allows_rd;
  assign push          = tlvp_ob_rd;
  assign wr_idx        = cnt_q - CW'(pop);
  assign cnt_d         = cnt_q + CW'(push) - CW'(pop);

  always_comb begin
    push_beat        = tlvp_ob;
    push_beat.tvalid = 1'b1;
  end

  // Entry 0 is always the head and drives the output port straight from flops; a pop shifts
  // everything down one slot and the pushed beat lands just behind the last surviving entry.
  for (genvar gi = 0; gi < N_OB_ENTRIES; gi++) begin : g_ent
    axi4s_dp_bus_t shifted;
    if (gi < N_OB_ENTRIES - 1) begin : g_mid
      assign shifted = pop ? ent_q[gi+1] : ent_q[gi];
    end else begin : g_last
      assign shifted = pop ? axi4s_dp_bus_t'('0) : ent_q[gi];
    end
    assign ent_d[gi] = (push && (wr_idx == CW'(gi))) ? push_beat : shifted;
  end

  // Frame tracking follows what has been read from the FIFO, not what has left downstream.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (frame_hold)                 state_d = HELD;
        else if (push && !tlvp_ob.tlast) state_d = IN_FRM;
      end
      IN_FRM:  if (push && tlvp_ob.tlast) state_d = IDLE;
      HELD:    if (!frame_hold)           state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  assign ob_held_d = (state_d == HELD) && (cnt_d == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ob_held_q   <= 1'b0;
      frame_cnt_q <= '0;
      beat_cnt_q  <= '0;
      for (int i = 0; i < N_OB_ENTRIES; i++) ent_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ob_held_q   <= ob_held_d;
      beat_cnt_q  <= beat_cnt_q + CNT_WIDTH'(pop);
      frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(pop & ent_q[0].tlast);
      for (int i = 0; i < N_OB_ENTRIES; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign axi4s_ob_out = ent_q[0];
  assign ob_held      = ob_held_q;
  assign ob_frame_cnt = frame_cnt_q;
  assign ob_beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_cr_tlvp_axi_out_mstr.sv
// Scoreboard bench: a queue-modelled show-ahead FIFO feeds the block, a negedge monitor checks
// every accepted beat against the expected queue, and directed scenarios check timing/counters.
module tb_cr_tlvp_axi_out_mstr;
  import cr_tlvp_axi_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          tlvp_ob_empty;
  logic          tlvp_ob_aempty;
  axi4s_dp_bus_t tlvp_ob;
  logic          tlvp_ob_rd;
  logic          frame_hold;
  axi4s_dp_rdy_t axi4s_ob_in;
  axi4s_dp_bus_t axi4s_ob_out;
  logic          ob_held;
  logic [3:0]    ob_frame_cnt;
  logic [3:0]    ob_beat_cnt;

  cr_tlvp_axi_out_mstr #(.N_OB_ENTRIES(2), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .tlvp_ob_empty(tlvp_ob_empty), .tlvp_ob_aempty(tlvp_ob_aempty),
    .tlvp_ob(tlvp_ob), .tlvp_ob_rd(tlvp_ob_rd), .frame_hold(frame_hold),
    .axi4s_ob_in(axi4s_ob_in), .axi4s_ob_out(axi4s_ob_out), .ob_held(ob_held),
    .ob_frame_cnt(ob_frame_cnt), .ob_beat_cnt(ob_beat_cnt)
  );

  always #5 clk = ~clk;

  axi4s_dp_bus_t src_q[$];
  axi4s_dp_bus_t exp_q[$];
  axi4s_dp_bus_t mon_e;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int first_rd = -1, first_tv = -1, first_acc = -1, last_acc = -1;
  int acc_n = 0, rd_n = 0;
  logic rd_pend = 1'b0;
  logic stall_chk = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic refresh();
    tlvp_ob_empty = (src_q.size() == 0);
    tlvp_ob       = (src_q.size() != 0) ? src_q[0] : axi4s_dp_bus_t'('0);
  endtask

  task automatic add_beat(input logic [63:0] d, input logic last);
    axi4s_dp_bus_t b;
    b.tvalid = 1'b1;
    b.tlast  = last;
    b.tid    = d[1:0];
    b.tuser  = d[7:0] ^ 8'h3C;
    b.tstrb  = 8'hFF;
    b.tdata  = d;
    src_q.push_back(b);
    exp_q.push_back(b);
    refresh();
  endtask

  // Inputs change only at posedge+1; the FIFO head advances when the last negedge saw rd.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rd_pend && src_q.size() != 0) void'(src_q.pop_front());
    refresh();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  always @(negedge clk) begin
    rd_pend = tlvp_ob_rd;
    if (tlvp_ob_rd) begin
      rd_n++;
      if (first_rd < 0) first_rd = cyc;
    end
  end

  always @(negedge clk) begin
    if (!rst && axi4s_ob_out.tvalid) begin
      if (first_tv < 0) first_tv = cyc;
      if (axi4s_ob_in.tready) begin
        acc_n++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 128'(axi4s_ob_out), 128'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_payload", 128'(axi4s_ob_out), 128'(mon_e));
        end
      end else if (stall_chk && exp_q.size() != 0) begin
        chk("stall_payload", 128'(axi4s_ob_out), 128'(exp_q[0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    rst = 1'b1;
    frame_hold = 1'b0;
    tlvp_ob_aempty = 1'b0;
    axi4s_ob_in.tready = 1'b0;
    refresh();
    run(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", 128'(axi4s_ob_out.tvalid), 128'(0));
    chk("rst_rd", 128'(tlvp_ob_rd), 128'(0));
    chk("rst_held", 128'(ob_held), 128'(0));
    chk("rst_frame_cnt", 128'(ob_frame_cnt), 128'(0));
    chk("rst_beat_cnt", 128'(ob_beat_cnt), 128'(0));

    // single-beat frame: tvalid one cycle after rd
    tick();
    axi4s_ob_in.tready = 1'b1;
    first_rd = -1; first_tv = -1;
    add_beat(64'hA5, 1'b1);
    run(5);
    chk("t1_latency", 128'(first_tv - first_rd), 128'(1));
    chk("t1_beat_cnt", 128'(ob_beat_cnt), 128'(1));
    chk("t1_frame_cnt", 128'(ob_frame_cnt), 128'(1));

    // 8-beat frame streams without bubbles
    acc_n = 0; first_acc = -1;
    for (int i = 0; i < 8; i++) add_beat(64'h200 + 64'(i), i == 7);
    run(15);
    chk("t2_accepts", 128'(acc_n), 128'(8));
    chk("t2_no_bubble", 128'(last_acc - first_acc), 128'(7));
    chk("t2_beat_cnt", 128'(ob_beat_cnt), 128'(9));
    chk("t2_frame_cnt", 128'(ob_frame_cnt), 128'(2));

    // backpressure: only two reads while stalled, head payload stable
    axi4s_ob_in.tready = 1'b0;
    stall_chk = 1'b1;
    rd_n = 0;
    for (int i = 0; i < 4; i++) add_beat(64'h300 + 64'(i), i == 3);
    run(5);
    chk("t3_rd_during_stall", 128'(rd_n), 128'(2));
    chk("t3_tvalid_held", 128'(axi4s_ob_out.tvalid), 128'(1));
    axi4s_ob_in.tready = 1'b1;
    stall_chk = 1'b0;
    run(8);
    chk("t3_exp_left", 128'(exp_q.size()), 128'(0));
    chk("t3_beat_cnt", 128'(ob_beat_cnt), 128'(13));
    chk("t3_frame_cnt", 128'(ob_frame_cnt), 128'(3));

    // frame_hold raised mid-frame parks after that frame's tlast
    for (int i = 0; i < 4; i++) add_beat(64'h400 + 64'(i), i == 3);
    for (int i = 0; i < 2; i++) add_beat(64'h500 + 64'(i), i == 1);
    k = 0;
    while (src_q.size() > 4 && k < 20) begin
      tick();
      k++;
    end
    chk("t4_arm", 128'(src_q.size()), 128'(4));
    frame_hold = 1'b1;
    run(8);
    chk("t4_held", 128'(ob_held), 128'(1));
    chk("t4_frame2_waiting", 128'(src_q.size()), 128'(2));
    chk("t4_beat_cnt_held", 128'(ob_beat_cnt), 128'(1));
    chk("t4_frame_cnt_held", 128'(ob_frame_cnt), 128'(4));
    frame_hold = 1'b0;
    run(6);
    chk("t4_unheld", 128'(ob_held), 128'(0));
    chk("t4_src_drained", 128'(src_q.size()), 128'(0));
    chk("t4_exp_left", 128'(exp_q.size()), 128'(0));
    chk("t4_beat_cnt", 128'(ob_beat_cnt), 128'(3));
    chk("t4_frame_cnt", 128'(ob_frame_cnt), 128'(5));

    // reset mid-frame with two beats buffered
    axi4s_ob_in.tready = 1'b0;
    for (int i = 0; i < 4; i++) add_beat(64'h600 + 64'(i), i == 3);
    run(3);
    chk("t5_tvalid_before", 128'(axi4s_ob_out.tvalid), 128'(1));
    rst = 1'b1;
    src_q.delete();
    exp_q.delete();
    refresh();
    tick();
    @(negedge clk);
    chk("t5_tvalid", 128'(axi4s_ob_out.tvalid), 128'(0));
    chk("t5_rd", 128'(tlvp_ob_rd), 128'(0));
    chk("t5_beat_cnt", 128'(ob_beat_cnt), 128'(0));
    chk("t5_frame_cnt", 128'(ob_frame_cnt), 128'(0));
    tick();
    rst = 1'b0;

    // 17 single-beat frames wrap the 4-bit counters to 1
    axi4s_ob_in.tready = 1'b1;
    for (int i = 0; i < 17; i++) add_beat(64'h700 + 64'(i), 1'b1);
    run(25);
    chk("t6_exp_left", 128'(exp_q.size()), 128'(0));
    chk("t6_frame_cnt", 128'(ob_frame_cnt), 128'(1));
    chk("t6_beat_cnt", 128'(ob_beat_cnt), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
